dmem_bus_bridge: RTL and testbench
==================================

# dmem_bus_bridge

Multi-cycle data-memory bridge between the CPU load/store path and a valid/ready data bus. It sits directly downstream of the load/store byte-lane logic: it consumes that logic's `byte_enable` and `mem_write_data` and returns the raw 32-bit word it turns back into `cpu_writeback_data`. The bridge stalls the single-cycle core while a bus transaction is outstanding. It also reports bus errors, response timeouts and misaligned stores.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `TIMEOUT`, 16: maximum cycles spent in `RSP`; 0 disables the timeout.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: load or store in the current instruction; held stable while `stall`=1.
- `req_is_store`  in  1: 1 = store, 0 = load.
- `req_addr`  in  ADDR_W: byte address from the ALU.
- `req_be`  in  4: byte enables from the byte-lane logic.
- `req_wdata`  in  32: store data, already lane-placed.
- `stall`  out  1: freeze PC and architectural state.
- `mem_read_data`  out  32: captured read word, fed to the byte-lane logic.
- `access_err`  out  1: one-cycle pulse in `DONE` when the access faulted.
- `err_cause`  out  2: 00 none, 01 bus error, 10 timeout, 11 misaligned store. Valid with `access_err`.
- `bus_req_valid`  out  1: request channel valid.
- `bus_req_ready`  in  1: request channel ready.
- `bus_addr`  out  ADDR_W: word-aligned address, `{req_addr[ADDR_W-1:2],2'b00}`.
- `bus_we`  out  1: write enable.
- `bus_be`  out  4: `req_be` for stores; 4'b1111 for loads.
- `bus_wdata`  out  32: write data.
- `bus_rsp_valid`  in  1: response valid.
- `bus_rsp_rdata`  in  32: response read data.
- `bus_rsp_err`  in  1: response error flag.

## Operation
- FSM states: `IDLE`, `REQ`, `RSP`, `DONE`.
- `IDLE`:
  - On `req_valid`=1 with a store whose `req_be`=0, go to `DONE` with cause 11. No bus transaction is issued.
  - On any other `req_valid`=1, register `bus_addr`, `bus_we`, `bus_be` and `bus_wdata`, then go to `REQ`.
- `REQ`:
  - `bus_req_valid`=1 and all request fields are held stable.
  - On `bus_req_ready`=1, go to `RSP` and clear the timeout counter.
  - There is no timeout in this state; bus protocol forbids withdrawing a request.
- `RSP`:
  - Increment the counter each cycle.
  - On `bus_rsp_valid`=1, go to `DONE`. Capture cause 01 if `bus_rsp_err`=1, otherwise cause 00.
  - For a load without error, `mem_read_data` ← `bus_rsp_rdata`.
  - For a store, or on error, `mem_read_data` ← 0.
  - If the counter reaches `TIMEOUT` and `TIMEOUT`≠0, go to `DONE` with cause 10 and `mem_read_data` ← 0.
  - If the response and the timeout coincide, the response wins.
- `DONE`:
  - `stall`=0, so the instruction retires on this edge.
  - `access_err`=1 iff cause≠00.
  - Always return to `IDLE`.
- `stall` = (`IDLE` && `req_valid`) || `REQ` || `RSP`. This is combinational from `req_valid`; all other outputs are registered.
- `bus_rsp_valid` is ignored outside `RSP`, including the acceptance cycle in `REQ`; stray responses have no effect.
- `mem_read_data` holds its value until the next capture.

## Timing
- Reset values:
  - State is `IDLE`.
  - `bus_req_valid`, `bus_we`, `access_err` and `stall` are 0, with `stall` recomputed from `req_valid`.
  - `bus_addr`, `bus_be`, `bus_wdata` and `mem_read_data` are 0.
  - `err_cause` is 00.
- Minimum latency, request in cycle 0:
  - Cycle 0: `IDLE`, `stall`=1.
  - Cycle 1: `REQ`, with `bus_req_ready`=1.
  - Cycle 2: `RSP`, with `bus_rsp_valid`=1.
  - Cycle 3: `DONE`, `stall`=0.
  - Total: 3 stall cycles.
- A misaligned store stalls for 1 cycle: `IDLE` then `DONE`.
- Timeout: with `TIMEOUT`=N, `DONE` occurs N cycles after entering `RSP`.
- A new request is sampled at the earliest in the cycle after `DONE`.
- Reset mid-operation: the transaction is abandoned and `bus_req_valid` drops asynchronously. A late response is ignored because the state is `IDLE`.

## Structure
- Package `dmem_pkg`:
  - `dmem_state_e` (the FSM states).
  - `dmem_err_e` (the error causes).
  - Store/load opcode constants 7'b0100011 and 7'b0000011.
- Sub-module `dmem_timeout_timer`:
  - Inputs: `clr`, `en`.
  - Output: `expired`.
  - Counter width `$clog2(TIMEOUT+1)`; saturates at the limit.

## Test plan
- Load word at 0x100, ready and response with rdata=0xDEADBEEF both immediate → `stall` high 3 cycles; in `DONE`, `mem_read_data`=0xDEADBEEF and `access_err`=0.
- Store at 0x202, `req_be`=4'b1100, wdata=0xABCD0000, ready delayed 4 cycles → `bus_addr`=0x200, `bus_be`=4'b1100, `bus_we`=1, fields stable for all 4 cycles, `stall` high 6 cycles.
- Store with `req_be`=0 → no `bus_req_valid`; one stall cycle; `access_err`=1, `err_cause`=11.
- Load with `bus_rsp_err`=1 → `err_cause`=01, `mem_read_data`=0. Separately, no response with `TIMEOUT`=16 → `DONE` 16 cycles after `RSP` entry, `err_cause`=10.
- Response arriving in the same cycle the counter reaches `TIMEOUT` → cause 00 and data captured. A stray `bus_rsp_valid` in `IDLE` → no state change.
- `rst_n` asserted while in `RSP` → `bus_req_valid`=0 immediately, state `IDLE`; a subsequent `bus_rsp_valid` is ignored.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus bridge.
package dmem_pkg;

    // Bridge FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_e;

    // Fault causes reported alongside access_err
    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_BUS      = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_MISALIGN = 2'b11
    } dmem_err_e;

    // RV32 major opcodes for the memory instructions this bridge serves
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    // Loads always fetch the full word; lane selection happens upstream
    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/dmem_bus_bridge_timer.sv
// Response timeout counter: cleared on request acceptance, counts while waiting
// for the response, saturates at TIMEOUT. TIMEOUT = 0 disables expiry.
module dmem_timeout_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned   CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);
    localparam bit            TO_EN = (TIMEOUT != 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise saturating increment while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expires in the cycle whose increment brings the count up to TIMEOUT
    assign expired = TO_EN && en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Multi-cycle bridge from the CPU load/store path to a valid/ready data bus.
// Stalls the core while a transaction is outstanding and reports faults.
module dmem_bus_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       mem_read_data,
    output logic              access_err,
    output logic [1:0]        err_cause,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rsp_rdata,
    input  logic              bus_rsp_err
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    dmem_state_e       state_q, state_d;
    logic              bus_req_valid_q, bus_req_valid_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_we_q, bus_we_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [31:0]       mem_read_data_q, mem_read_data_d;
    logic              access_err_q, access_err_d;
    dmem_err_e         err_cause_q, err_cause_d;

    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_expired;

    dmem_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Next-state and next-output logic for the bridge FSM
    always_comb begin
        state_d         = state_q;
        bus_req_valid_d = bus_req_valid_q;
        bus_addr_d      = bus_addr_q;
        bus_we_d        = bus_we_q;
        bus_be_d        = bus_be_q;
        bus_wdata_d     = bus_wdata_q;
        mem_read_data_d = mem_read_data_q;
        access_err_d    = 1'b0;
        err_cause_d     = err_cause_q;
        tmr_clr         = 1'b0;
        tmr_en          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_is_store && (req_be == 4'b0000)) begin
                        state_d      = ST_DONE;
                        err_cause_d  = ERR_MISALIGN;
                        access_err_d = 1'b1;
                    end else begin
                        state_d         = ST_REQ;
                        bus_req_valid_d = 1'b1;
                        bus_addr_d      = req_addr & WORD_MASK;
                        bus_we_d        = req_is_store;
                        bus_be_d        = req_is_store ? req_be : BE_ALL;
                        bus_wdata_d     = req_wdata;
                    end
                end
            end
            ST_REQ: begin
                if (bus_req_ready) begin
                    state_d         = ST_RSP;
                    bus_req_valid_d = 1'b0;
                    tmr_clr         = 1'b1;
                end
            end
            ST_RSP: begin
                tmr_en = 1'b1;
                // A response in the expiry cycle takes priority over the timeout
                if (bus_rsp_valid) begin
                    state_d         = ST_DONE;
                    err_cause_d     = bus_rsp_err ? ERR_BUS : ERR_NONE;
                    access_err_d    = bus_rsp_err;
                    mem_read_data_d = (!bus_we_q && !bus_rsp_err) ? bus_rsp_rdata : '0;
                end else if (tmr_expired) begin
                    state_d         = ST_DONE;
                    err_cause_d     = ERR_TIMEOUT;
                    access_err_d    = 1'b1;
                    mem_read_data_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            bus_req_valid_q <= 1'b0;
            bus_addr_q      <= '0;
            bus_we_q        <= 1'b0;
            bus_be_q        <= '0;
            bus_wdata_q     <= '0;
            mem_read_data_q <= '0;
            access_err_q    <= 1'b0;
            err_cause_q     <= ERR_NONE;
        end else begin
            state_q         <= state_d;
            bus_req_valid_q <= bus_req_valid_d;
            bus_addr_q      <= bus_addr_d;
            bus_we_q        <= bus_we_d;
            bus_be_q        <= bus_be_d;
            bus_wdata_q     <= bus_wdata_d;
            mem_read_data_q <= mem_read_data_d;
            access_err_q    <= access_err_d;
            err_cause_q     <= err_cause_d;
        end
    end

    // Stall is combinational so the core freezes in the cycle the request appears
    always_comb begin
        stall = ((state_q == ST_IDLE) && req_valid) ||
                (state_q == ST_REQ) || (state_q == ST_RSP);
    end

    assign bus_req_valid = bus_req_valid_q;
    assign bus_addr      = bus_addr_q;
    assign bus_we        = bus_we_q;
    assign bus_be        = bus_be_q;
    assign bus_wdata     = bus_wdata_q;
    assign mem_read_data = mem_read_data_q;
    assign access_err    = access_err_q;
    assign err_cause     = err_cause_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed self-checking bench for dmem_bus_bridge (TIMEOUT = 16).
module tb_dmem_bus_bridge;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_is_store;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] mem_read_data;
    logic        access_err;
    logic [1:0]  err_cause;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;

    int checks = 0;
    int errors = 0;

    dmem_bus_bridge #(
        .ADDR_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_is_store  (req_is_store),
        .req_addr      (req_addr),
        .req_be        (req_be),
        .req_wdata     (req_wdata),
        .stall         (stall),
        .mem_read_data (mem_read_data),
        .access_err    (access_err),
        .err_cause     (err_cause),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_addr      (bus_addr),
        .bus_we        (bus_we),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata),
        .bus_rsp_err   (bus_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic st, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
        req_valid    = v;
        req_is_store = st;
        req_addr     = a;
        req_be       = be;
        req_wdata    = wd;
    endtask

    task automatic set_bus(input logic rdy, input logic rv, input logic [31:0] rd, input logic re);
        bus_req_ready = rdy;
        bus_rsp_valid = rv;
        bus_rsp_rdata = rd;
        bus_rsp_err   = re;
    endtask

    initial begin
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) tick();

        // Reset values
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_brv", 32'(bus_req_valid), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_aerr", 32'(access_err), 32'd0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_be", 32'(bus_be), 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_rdata", mem_read_data, 32'h0);
        chk("rst_cause", 32'(err_cause), 32'd0);
        rst_n = 1'b1;
        tick();

        // Load word at 0x100, immediate ready and response
        set_req(1'b1, 1'b0, 32'h100, 4'b0011, 32'h1111_2222);
        set_bus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        #1;
        chk("ld_c0_stall", 32'(stall), 32'd1);
        tick();
        chk("ld_c1_stall", 32'(stall), 32'd1);
        chk("ld_c1_brv", 32'(bus_req_valid), 32'd1);
        chk("ld_c1_addr", bus_addr, 32'h100);
        chk("ld_c1_we", 32'(bus_we), 32'd0);
        chk("ld_c1_be", 32'(bus_be), 32'hF);
        tick();
        chk("ld_c2_stall", 32'(stall), 32'd1);
        chk("ld_c2_brv", 32'(bus_req_valid), 32'd0);
        tick();
        chk("ld_done_stall", 32'(stall), 32'd0);
        chk("ld_done_rdata", mem_read_data, 32'hDEAD_BEEF);
        chk("ld_done_aerr", 32'(access_err), 32'd0);
        chk("ld_done_cause", 32'(err_cause), 32'd0);
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("ld_idle_aerr", 32'(access_err), 32'd0);

        // Load whose response arrives in the cycle the timeout would fire
        set_req(1'b1, 1'b0, 32'h44, 4'hF, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        for (int j = 1; j <= 16; j++) begin
            if (j == 16) set_bus(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
            #1;
            chk("co_rsp_stall", 32'(stall), 32'd1);
            tick();
        end
        chk("co_done_stall", 32'(stall), 32'd0);
        chk("co_done_aerr", 32'(access_err), 32'd0);
        chk("co_done_cause", 32'(err_cause), 32'd0);
        chk("co_done_rdata", mem_read_data, 32'hCAFE_F00D);
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();

        // Load with no response: times out 16 cycles after entering RSP
        set_req(1'b1, 1'b0, 32'h80, 4'hF, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        for (int j = 1; j <= 16; j++) begin
            #1;
            chk("to_rsp_stall", 32'(stall), 32'd1);
            tick();
        end
        chk("to_done_stall", 32'(stall), 32'd0);
        chk("to_done_aerr", 32'(access_err), 32'd1);
        chk("to_done_cause", 32'(err_cause), 32'd2);
        chk("to_done_rdata", mem_read_data, 32'h0);
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("to_idle_aerr", 32'(access_err), 32'd0);

        // Stray response while idle has no effect
        set_bus(1'b1, 1'b1, 32'h5555_5555, 1'b1);
        #1;
        chk("stray_stall", 32'(stall), 32'd0);
        tick();
        tick();
        chk("stray_brv", 32'(bus_req_valid), 32'd0);
        chk("stray_aerr", 32'(access_err), 32'd0);
        chk("stray_rdata", mem_read_data, 32'h0);
        chk("stray_cause", 32'(err_cause), 32'd2);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);

        // Seed read data, then a bus-error load must clear it
        set_req(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        set_bus(1'b1, 1'b1, 32'h0BAD_F00D, 1'b0);
        repeat (3) tick();
        chk("seed_rdata", mem_read_data, 32'h0BAD_F00D);
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        set_req(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        set_bus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        repeat (3) tick();
        chk("be_done_stall", 32'(stall), 32'd0);
        chk("be_done_aerr", 32'(access_err), 32'd1);
        chk("be_done_cause", 32'(err_cause), 32'd1);
        chk("be_done_rdata", mem_read_data, 32'h0);
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();

        // Store at 0x202, ready asserted only in the fourth REQ cycle
        set_req(1'b1, 1'b1, 32'h202, 4'b1100, 32'hABCD_0000);
        #1;
        chk("st_c0_stall", 32'(stall), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) set_bus(1'b1, 1'b0, 32'h0, 1'b0);
            #1;
            chk("st_req_stall", 32'(stall), 32'd1);
            chk("st_req_brv", 32'(bus_req_valid), 32'd1);
            chk("st_req_addr", bus_addr, 32'h200);
            chk("st_req_be", 32'(bus_be), 32'hC);
            chk("st_req_we", 32'(bus_we), 32'd1);
            chk("st_req_wdata", bus_wdata, 32'hABCD_0000);
            tick();
        end
        set_bus(1'b0, 1'b1, 32'h1234_5678, 1'b0);
        #1;
        chk("st_rsp_stall", 32'(stall), 32'd1);
        chk("st_rsp_brv", 32'(bus_req_valid), 32'd0);
        tick();
        chk("st_done_stall", 32'(stall), 32'd0);
        chk("st_done_aerr", 32'(access_err), 32'd0);
        chk("st_done_rdata", mem_read_data, 32'h0);
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();

        // Store with no byte enables: one stall cycle, no bus traffic
        set_req(1'b1, 1'b1, 32'h300, 4'b0000, 32'h7777_7777);
        set_bus(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("mis_c0_stall", 32'(stall), 32'd1);
        tick();
        chk("mis_done_stall", 32'(stall), 32'd0);
        chk("mis_done_brv", 32'(bus_req_valid), 32'd0);
        chk("mis_done_aerr", 32'(access_err), 32'd1);
        chk("mis_done_cause", 32'(err_cause), 32'd3);
        chk("mis_done_addr", bus_addr, 32'h200);
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("mis_idle_aerr", 32'(access_err), 32'd0);
        chk("mis_idle_brv", 32'(bus_req_valid), 32'd0);

        // Reset while a request is pending in REQ: valid drops at once
        set_req(1'b1, 1'b0, 32'h500, 4'hF, 32'h0);
        tick();
        chk("rq_brv_before", 32'(bus_req_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rq_brv_async", 32'(bus_req_valid), 32'd0);
        chk("rq_addr_async", bus_addr, 32'h0);
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset while waiting in RSP; a late response is then ignored
        set_req(1'b1, 1'b0, 32'h600, 4'hF, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("rr_stall_rsp", 32'(stall), 32'd1);
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("rr_stall_held", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_stall_async", 32'(stall), 32'd0);
        chk("rr_brv_async", 32'(bus_req_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        set_bus(1'b0, 1'b1, 32'h9999_9999, 1'b0);
        tick();
        tick();
        chk("rr_late_stall", 32'(stall), 32'd0);
        chk("rr_late_aerr", 32'(access_err), 32'd0);
        chk("rr_late_rdata", mem_read_data, 32'h0);
        chk("rr_late_brv", 32'(bus_req_valid), 32'd0);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
